// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and sizing helpers for the sequential divider
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // Counter must hold values up to WIDTH_N-1 with headroom for the last step.
  function automatic int cnt_width(input int width_n);
    return $clog2(width_n + 1);
  endfunction

endpackage

// File: rtl/divider_seq_step.sv
// rtl/divider_seq_step.sv - one restoring-division iteration: shift, trial-subtract, restore
module div_step #(
  parameter int WIDTH_D = 16
) (
  input  logic [WIDTH_D:0]   rem_in,
  input  logic               n_bit,
  input  logic [WIDTH_D-1:0] d_abs,
  output logic [WIDTH_D:0]   rem_out,
  output logic               q_bit
);

  logic [WIDTH_D+1:0] shifted;
  logic [WIDTH_D+1:0] diff;

  always_comb begin
    shifted = {rem_in, n_bit};
    diff    = shifted - {2'b00, d_abs};
    q_bit   = (shifted >= {2'b00, d_abs});
    // Remainder stays below |D|, so the top bit of either candidate is always zero.
    rem_out = q_bit ? (WIDTH_D+1)'(diff) : (WIDTH_D+1)'(shifted);
  end

endmodule

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - radix-2 restoring divider with valid/ready handshake, signed or unsigned
module divider_seq
  import divider_pkg::*;
#(
  parameter bit SIGNED  = 1'b0,
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] N,
  input  logic [WIDTH_D-1:0] D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] Q,
  output logic [WIDTH_D-1:0] R,
  output logic               dz
);

  localparam int CW = cnt_width(WIDTH_N);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH_N-1:0] dvd;
  logic [WIDTH_D:0]   rem;
  logic [WIDTH_D-1:0] dsr;
  logic               neg_q, neg_r;

  logic               accept, d_zero, last_step;
  logic               n_neg, d_neg;
  logic [WIDTH_N-1:0] n_abs;
  logic [WIDTH_D-1:0] d_abs;
  logic [WIDTH_D:0]   rem_nxt;
  logic               q_bit;

  // Most-negative operands map onto their own bit pattern, which is the correct unsigned magnitude.
  always_comb begin
    accept    = in_valid & in_ready;
    d_zero    = (D == '0);
    last_step = (cnt == CW'(WIDTH_N - 1));
    n_neg     = SIGNED & N[WIDTH_N-1];
    d_neg     = SIGNED & D[WIDTH_D-1];
    n_abs     = n_neg ? -N : N;
    d_abs     = d_neg ? -D : D;
  end

  div_step #(.WIDTH_D(WIDTH_D)) u_step (
    .rem_in  (rem),
    .n_bit   (dvd[WIDTH_N-1]),
    .d_abs   (dsr),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = d_zero ? DONE : CALC;
      end
      CALC: if (last_step) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The dividend register doubles as the quotient: bits leave at the top, quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      dvd   <= '0;
      rem   <= '0;
      dsr   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      Q     <= '0;
      R     <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt   <= '0;
          dvd   <= n_abs;
          dsr   <= d_abs;
          rem   <= '0;
          neg_q <= n_neg ^ d_neg;
          neg_r <= n_neg;
          if (d_zero) begin
            Q  <= '1;
            R  <= '0;
            dz <= 1'b1;
          end
        end
        CALC: begin
          dvd <= {dvd[WIDTH_N-2:0], q_bit};
          rem <= rem_nxt;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          Q  <= neg_q ? -dvd : dvd;
          R  <= neg_r ? -rem[WIDTH_D-1:0] : rem[WIDTH_D-1:0];
          dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - scoreboard bench driving unsigned and signed divider instances in lockstep
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] n_in, d_in;
  logic        rdy_u, rdy_s, ov_u, ov_s, dz_u, dz_s;
  logic [15:0] q_u, q_s, r_u, r_s;

  typedef struct {
    logic [15:0] q_u, r_u, q_s, r_s;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  divider_seq #(.SIGNED(1'b0), .WIDTH_N(16), .WIDTH_D(16)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
    .N(n_in), .D(d_in), .out_valid(ov_u), .out_ready(out_ready),
    .Q(q_u), .R(r_u), .dz(dz_u)
  );

  divider_seq #(.SIGNED(1'b1), .WIDTH_N(16), .WIDTH_D(16)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
    .N(n_in), .D(d_in), .out_valid(ov_s), .out_ready(out_ready),
    .Q(q_s), .R(r_s), .dz(dz_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [15:0] n, input logic [15:0] d);
    exp_t e;
    int   ns, ds;
    if (d == 16'd0) begin
      e.q_u = 16'hFFFF; e.r_u = 16'd0; e.q_s = 16'hFFFF; e.r_s = 16'd0; e.dz = 1'b1;
    end else begin
      e.q_u = n / d;
      e.r_u = n % d;
      ns    = $signed(n);
      ds    = $signed(d);
      e.q_s = 16'(ns / ds);
      e.r_s = 16'(ns % ds);
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; accepts on the following posedge and consumes the result.
  task automatic run_op(input logic [15:0] n, input logic [15:0] d, input int hold);
    int          edges;
    exp_t        e;
    logic [63:0] snap;
    chk("in_ready_before", {rdy_u, rdy_s}, 2'b11);
    n_in = n; d_in = d; in_valid = 1'b1;
    sb.push_back(model(n, d));
    @(negedge clk);
    in_valid = 1'b0;
    n_in = 16'($urandom); d_in = 16'($urandom);
    edges = 0;
    while (!ov_u && edges < 64) begin
      @(negedge clk);
      edges++;
    end
    chk("latency", edges, (d == 16'd0) ? 0 : 17);
    chk("out_valid_both", {ov_u, ov_s}, 2'b11);
    snap = {q_u, r_u, q_s, r_s};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; n_in = 16'($urandom); d_in = 16'($urandom_range(1, 65535));
      @(negedge clk);
      chk("bp_in_ready", {rdy_u, rdy_s}, 2'b00);
      chk("bp_out_valid", {ov_u, ov_s}, 2'b11);
      chk("bp_stable", {q_u, r_u, q_s, r_s}, snap);
    end
    in_valid = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("q_uns", q_u, e.q_u);
      chk("r_uns", r_u, e.r_u);
      chk("q_sgn", q_s, e.q_s);
      chk("r_sgn", r_s, e.r_s);
      chk("dz", {dz_u, dz_s}, {e.dz, e.dz});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("consumed_valid", {ov_u, ov_s}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; n_in = '0; d_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {rdy_u, rdy_s}, 2'b11);
    chk("rst_valid", {ov_u, ov_s}, 2'b00);
    chk("rst_q_r", {q_u, r_u, q_s, r_s}, 64'd0);
    chk("rst_dz", {dz_u, dz_s}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd100,   16'd7,    0);
    run_op(16'hFF9C,  16'd7,    0);
    run_op(16'd100,   16'hFFF9, 0);
    run_op(16'hFF9C,  16'hFFF9, 0);
    run_op(16'h1234,  16'd0,    0);
    run_op(16'd9,     16'd3,    0);
    run_op(16'h8000,  16'hFFFF, 0);
    run_op(16'hFFFF,  16'd1,    0);
    run_op(16'd500,   16'd13,   10);
    for (int i = 0; i < 8; i++)
      run_op(16'($urandom), (i % 2 == 0) ? 16'($urandom_range(1, 40)) : 16'($urandom), 0);

    chk("pre_abort_ready", {rdy_u, rdy_s}, 2'b11);
    n_in = 16'd200; d_in = 16'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {ov_u, ov_s}, 2'b00);
    chk("abort_q_r", {q_u, r_u, q_s, r_s}, 64'd0);
    chk("abort_ready", {rdy_u, rdy_s}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd200, 16'd9, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
